// File: rtl/fifo_serializer.sv
// fifo_serializer: drains a show-ahead FIFO and emits each word LSB first.
// Optional even-parity beat per word when FIFO_SERIALIZER_PARITY_EN is defined.
module fifo_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              ser_valid_o,
    output logic              ser_data_o,
    input  logic              ser_ready_i,
    output logic              ser_last_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef FIFO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              fire;
    logic              final_fire;

    // Beat outputs decoded straight from the held state and shift register.
    always_comb begin
        ser_valid_o = (state_q != IDLE);
        busy_o      = (state_q != IDLE);
        ser_data_o  = 1'b0;
        ser_last_o  = 1'b0;
        if (state_q == SHIFT) begin
            ser_data_o = shreg_q[0];
`ifndef FIFO_SERIALIZER_PARITY_EN
            ser_last_o = (cnt_q == LAST_CNT);
`endif
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        if (state_q == PARITY) begin
            ser_data_o = par_q;
            ser_last_o = 1'b1;
        end
`endif
    end

    // Pop/reload decision and next-state logic; a final-beat handshake with
    // data waiting reloads in the same cycle so words run back to back.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
        par_d      = par_q;
`endif
        fire       = ser_valid_o & ser_ready_i;
        final_fire = fire & ser_last_o;
        fifo_pop_o = !reset && !fifo_empty_i &&
                     ((state_q == IDLE) || final_fire);

        if (fifo_pop_o) begin
            shreg_d = fifo_data_i;
            cnt_d   = '0;
            state_d = SHIFT;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_d   = ^fifo_data_i;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (fire) begin
                        shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
`ifdef FIFO_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (fire) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, shift register and counter; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: queue-based FIFO model, per-beat scoreboard,
// directed word scenarios followed by randomized traffic.
module tb_fifo_serializer;

    localparam int DATA_W = 8;
`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam int BEATS = DATA_W + 1;
`else
    localparam int BEATS = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_pop_o;
    logic              ser_valid_o;
    logic              ser_data_o;
    logic              ser_ready_i;
    logic              ser_last_o;
    logic              busy_o;

    typedef struct packed {
        logic b;
        logic l;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] fifo[$];
    int                checks   = 0;
    int                failures = 0;
    bit                pop_seen = 1'b0;
    bit                prev_rst = 1'b0;

    fifo_serializer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .ser_valid_o  (ser_valid_o),
        .ser_data_o   (ser_data_o),
        .ser_ready_i  (ser_ready_i),
        .ser_last_o   (ser_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic fifo_pins();
        fifo_empty_i = (fifo.size() == 0);
        if (fifo.size() != 0) fifo_data_i = fifo[0];
        else fifo_data_i = '0;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo.push_back(w);
        fifo_pins();
    endtask

    // Expected beats of one word: LSB first, optional even-parity beat last.
    task automatic expect_word(input logic [DATA_W-1:0] w);
        beat_t bt;
        for (int i = 0; i < DATA_W; i++) begin
            bt.b = w[i];
            bt.l = (i == BEATS - 1);
            exp_q.push_back(bt);
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        bt.b = ^w;
        bt.l = 1'b1;
        exp_q.push_back(bt);
`endif
    endtask

    // FIFO model consumes its head after the edge at which a pop was seen.
    always @(posedge clk) begin
        #1;
        if (pop_seen) begin
            void'(fifo.pop_front());
            pop_seen = 1'b0;
            fifo_pins();
        end
    end

    // Monitor: compares every presented beat and the pop strobe to the model.
    always @(negedge clk) begin
        bit fin;
        bit want;
        #2;
        fin = 1'b0;
        if (prev_rst) begin
            chk("rst_valid", ser_valid_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_last", ser_last_o, 0);
            chk("rst_data", ser_data_o, 0);
        end
        if (reset) begin
            chk("rst_pop", fifo_pop_o, 0);
            exp_q.delete();
        end else begin
            if (ser_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_beat got=valid exp=idle t=%0t", $time);
                end else begin
                    chk("data", ser_data_o, exp_q[0].b);
                    chk("last", ser_last_o, exp_q[0].l);
                    chk("busy", busy_o, 1);
                    if (ser_ready_i) begin
                        fin = exp_q[0].l;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_pending", exp_q.size(), 0);
                chk("idle_busy", busy_o, 0);
                chk("idle_last", ser_last_o, 0);
            end
            want = !fifo_empty_i && (exp_q.size() == 0);
            chk("pop", fifo_pop_o, want);
            if (fifo_pop_o && !fifo_empty_i) begin
                expect_word(fifo[0]);
                pop_seen = 1'b1;
            end
        end
        prev_rst = reset;
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo.size() == 0 && exp_q.size() == 0 && !ser_valid_o) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout got=busy exp=idle t=%0t", $time);
    endtask

    task automatic wait_left(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == n) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_timeout got=%0d exp=%0d t=%0t", exp_q.size(), n, $time);
    endtask

    initial begin
        reset       = 1'b1;
        ser_ready_i = 1'b0;
        fifo_pins();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // single word, ready held high
        ser_ready_i = 1'b1;
        push(8'hA5);
        drain(100);

        // two back-to-back words, no bubble
        push(8'h01);
        push(8'h80);
        drain(100);

        // stall for 3 cycles while bit 4 is presented
        push(8'hF0);
        wait_left(BEATS - 4, 100);
        ser_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        ser_ready_i = 1'b1;
        drain(100);

        // reset while bit 4 of 0x3C is presented, 0x55 waiting
        push(8'h3C);
        push(8'h55);
        wait_left(BEATS - 4, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drain(100);

        // FIFO empty for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ser_ready_i = 1'($urandom_range(0, 1));
        end

        // randomized traffic with backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 149) == 0);
            ser_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo.size() < 4)
                push(DATA_W'($urandom));
        end
        reset       = 1'b0;
        ser_ready_i = 1'b1;
        drain(200);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
